// File: rtl/mem_pkg.sv
// Shared encodings and types for the byte-addressed MIPS data memory.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    function automatic int calcAddrWidth(input int depthWords);
        return $clog2(depthWords);
    endfunction

endpackage

// File: rtl/data_ram_pipe_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface data_ram_pipe_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane steering: byte enables and replicated store data,
// load extraction with sign/zero extension, and alignment checking.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rdByte;
    logic [15:0] rdHalf;

    assign rdByte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign rdHalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_e'(size_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & rdByte[7]}}, rdByte};
            end
            SZ_HALF: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{signed_i & rdHalf[15]}}, rdHalf};
            end
            SZ_WORD: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
        if (misalign_o) begin
            be_o = 4'b0000;
        end
    end

endmodule

// File: rtl/data_ram_pipe.sv
// Byte-addressed data memory with valid/ready handshake, READ_LAT-deep
// response pipeline and back-pressure that freezes the whole pipe.
module data_ram_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1
) (
    input logic            clk,
    input logic            rst_n,
    data_ram_pipe_if.slave bus
);

    localparam int AW = calcAddrWidth(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    rsp_t          stage_q [READ_LAT];
    rsp_t          stage_d [READ_LAT];
    rsp_t          newRsp;

    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord;
    logic [31:0]   fmtRdata;
    logic [31:0]   fmtWword;
    logic [3:0]    fmtBe;
    logic          fmtMisalign;
    logic          rangeErr;
    logic          sizeErr;
    logic          reqErr;
    logic          advance;
    logic          accept;
    logic          wrEn;

    assign wordIdx  = bus.req_addr[AW+1:2];
    assign rangeErr = |bus.req_addr[31:AW+2];
    assign sizeErr  = (bus.req_size == SZ_RSVD);
    assign reqErr   = fmtMisalign | rangeErr | sizeErr;

    // The pipe moves only when the output slot is empty or being drained.
    assign advance = !stage_q[READ_LAT-1].valid || bus.rsp_ready;
    assign accept  = bus.req_valid && advance;
    assign wrEn    = accept && bus.req_we && !reqErr;
    assign rdWord  = mem_q[wordIdx];

    mem_lane_fmt u_fmt (
        .size_i     (bus.req_size),
        .signed_i   (bus.req_signed),
        .addr_lo_i  (bus.req_addr[1:0]),
        .wdata_i    (bus.req_wdata),
        .rword_i    (rdWord),
        .be_o       (fmtBe),
        .wword_o    (fmtWword),
        .rdata_o    (fmtRdata),
        .misalign_o (fmtMisalign)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrEn && fmtBe[i]) begin
                mem_q[wordIdx][8*i +: 8] <= fmtWword[8*i +: 8];
            end
        end
    end

    always_comb begin
        newRsp = '0;
        if (accept) begin
            newRsp.valid = 1'b1;
            newRsp.err   = reqErr;
            newRsp.rdata = (reqErr || bus.req_we) ? 32'h0 : fmtRdata;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (advance) begin
            stage_d[0] = newRsp;
            for (int i = 1; i < READ_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.req_ready = advance;
    assign bus.rsp_valid = stage_q[READ_LAT-1].valid;
    assign bus.rsp_rdata = stage_q[READ_LAT-1].rdata;
    assign bus.rsp_err   = stage_q[READ_LAT-1].err;

endmodule
